// File: rtl/simp_pkg.sv
// Shared definitions for the SIMP sequencer: FSM states, opcode classes,
// instruction field constants and LD register-select codes.
package simp_pkg;

    typedef enum logic [2:0] {
        FETCH,
        IRLD,
        EXEC,
        LDWB,
        HLT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ALU,
        OP_NIB,
        OP_JMP,
        OP_JN,
        OP_LD,
        OP_ST,
        OP_GET,
        OP_PUT,
        OP_HALT
    } op_class_t;

    // Upper-nibble opcodes for the non-ALU, non-NIB instructions
    localparam logic [3:0] OPC_MISC = 4'b0000;
    localparam logic [3:0] OPC_ST   = 4'b0001;
    localparam logic [3:0] OPC_GET  = 4'b0010;
    localparam logic [3:0] OPC_PUT  = 4'b0011;
    localparam logic [3:0] OPC_JMP  = 4'b0110;
    localparam logic [3:0] OPC_JN   = 4'b0111;

    // NIB is identified by its top three bits; bit 4 picks the nibble
    localparam logic [2:0] OPC_NIB  = 3'b010;

    // Full encoding of HALT inside the 0000_xxxx group
    localparam logic [7:0] IR_HALT  = 8'h0F;

    // LD destination register codes (IR[1:0])
    localparam logic [1:0] RR_A = 2'b00;
    localparam logic [1:0] RR_B = 2'b01;
    localparam logic [1:0] RR_V = 2'b10;
    localparam logic [1:0] RR_X = 2'b11;

endpackage

// File: rtl/simp_decode.sv
// Combinational instruction decoder: classifies the IR into an opcode class
// and extracts the LD register select and the compare-op flag.
module simp_decode
    import simp_pkg::*;
(
    input  logic [7:0] ir,
    output op_class_t  op_class,
    output logic [1:0] rr,
    output logic       les_leq
);

    assign rr      = ir[1:0];
    assign les_leq = ir[7] & (ir[6:5] == 2'b11);

    // Priority decode: ALU on bit 7, then NIB on the top three bits, then the upper nibble
    always_comb begin
        op_class = OP_NOP;
        if (ir[7]) begin
            op_class = OP_ALU;
        end else if (ir[7:5] == OPC_NIB) begin
            op_class = OP_NIB;
        end else begin
            case (ir[7:4])
                OPC_JMP: op_class = OP_JMP;
                OPC_JN:  op_class = OP_JN;
                OPC_ST:  op_class = OP_ST;
                OPC_GET: op_class = OP_GET;
                OPC_PUT: op_class = OP_PUT;
                OPC_MISC: begin
                    if (ir == IR_HALT) begin
                        op_class = OP_HALT;
                    end else if (ir[3:2] == 2'b00) begin
                        op_class = OP_LD;
                    end else begin
                        op_class = OP_NOP;
                    end
                end
                default: op_class = OP_NOP;
            endcase
        end
    end

endmodule

// File: rtl/simp_sequencer.sv
// SIMP fetch/decode/execute controller: owns PC, IR and the FSM, and drives
// the register unit enables/selects, memory strobes and IN/OUT handshakes.
module simp_sequencer
    import simp_pkg::*;
(
    input  logic       ck,
    input  logic       rst,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] V,
    input  logic       N,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       in_ack,
    output logic       out_valid,
    output logic       set_A,
    output logic       set_B,
    output logic       set_V,
    output logic       set_X,
    output logic       iget,
    output logic       hi_lo_V,
    output logic       les_leq,
    output logic       i4,
    output logic       i7,
    output logic [3:0] V_nibble,
    output logic [2:0] alu_op,
    output logic       halted
);

    state_t    state;
    state_t    state_nxt;
    logic [7:0] pc;
    logic [7:0] ir;
    op_class_t op_class;
    logic [1:0] rr;

    simp_decode u_decode (
        .ir       (ir),
        .op_class (op_class),
        .rr       (rr),
        .les_leq  (les_leq)
    );

    assign i4       = ir[4];
    assign i7       = ir[7];
    assign V_nibble = ir[3:0];
    assign alu_op   = ir[6:4];
    assign in_ack   = iget;

    // State, PC and IR registers; IR loads in IRLD, jumps retarget PC at the end of EXEC
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= FETCH;
            pc    <= 8'h00;
            ir    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IRLD) begin
                ir <= mem_rdata;
                pc <= pc + 8'd1;
            end
            if (state == EXEC && (op_class == OP_JMP || (op_class == OP_JN && N))) begin
                pc <= V;
            end
        end
    end

    // Next-state and control strobes; every strobe is forced low while rst is high
    always_comb begin
        state_nxt = state;
        mem_addr  = pc;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        out_valid = 1'b0;
        set_A     = 1'b0;
        set_B     = 1'b0;
        set_V     = 1'b0;
        set_X     = 1'b0;
        iget      = 1'b0;
        hi_lo_V   = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                mem_rd    = 1'b1;
                state_nxt = IRLD;
            end
            IRLD: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = FETCH;
                case (op_class)
                    OP_ALU: set_X = 1'b1;
                    OP_NIB: begin
                        set_V   = 1'b1;
                        hi_lo_V = 1'b1;
                    end
                    OP_ST: begin
                        mem_addr = V;
                        mem_wr   = 1'b1;
                    end
                    OP_LD: begin
                        mem_addr  = V;
                        mem_rd    = 1'b1;
                        state_nxt = LDWB;
                    end
                    OP_GET: begin
                        iget  = in_valid;
                        set_A = in_valid;
                        if (!in_valid) state_nxt = EXEC;
                    end
                    OP_PUT: begin
                        out_valid = 1'b1;
                        if (!out_ready) state_nxt = EXEC;
                    end
                    OP_HALT: state_nxt = HLT;
                    default: state_nxt = FETCH;
                endcase
            end
            LDWB: begin
                state_nxt = FETCH;
                case (rr)
                    RR_A:    set_A = 1'b1;
                    RR_B:    set_B = 1'b1;
                    RR_V:    set_V = 1'b1;
                    default: set_X = 1'b1;
                endcase
            end
            HLT: begin
                halted    = 1'b1;
                state_nxt = HLT;
            end
            default: state_nxt = FETCH;
        endcase
        if (rst) begin
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            out_valid = 1'b0;
            set_A     = 1'b0;
            set_B     = 1'b0;
            set_V     = 1'b0;
            set_X     = 1'b0;
            iget      = 1'b0;
            hi_lo_V   = 1'b0;
        end
    end

endmodule

// File: doc/simp_sequencer.md
# simp_sequencer

Multi-cycle fetch/decode/execute controller for the SIMP core, sitting directly upstream of the register unit. It fetches 8-bit instructions from memory and decodes them. It then drives every load-enable and select line the register unit consumes (`set_A`/`set_B`/`set_V`/`set_X`, `iget`, `hi_lo_V`, `les_leq`, `i4`, `i7`, `V_nibble`). It owns the program counter, the instruction register, memory read/write strobes and the IN/OUT handshakes.

## Interface
- No parameters; data and address width fixed at 8 bits.
- `ck`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_rdata`  in  8  memory read data, valid the cycle after `mem_rd`.
- `V`  in  8  register unit V output, used as data address and jump target.
- `N`  in  1  ALU negative flag, sampled in EXEC of JN.
- `in_valid`  in  1  IN port holds a byte.
- `out_ready`  in  1  OUT consumer accepts.
- `mem_addr`  out  8  PC in FETCH, V in EXEC of LD/ST.
- `mem_rd` / `mem_wr`  out  1  memory strobes; `mem_wr` writes A (muxed externally).
- `in_ack`  out  1  equals `iget`.
- `out_valid`  out  1  OUT byte (A) offered.
- `set_A`, `set_B`, `set_V`, `set_X`, `iget`, `hi_lo_V`, `les_leq`  out  1  register unit controls.
- `i4`, `i7`  out  1  IR[4], IR[7].
- `V_nibble`  out  4  IR[3:0].
- `alu_op`  out  3  IR[6:4].
- `halted`  out  1  HALT state.

## Operation
- Encoding (IR):
  - `1ooo_xxxx`: ALU, X←result.
  - `010s_nnnn`: NIB, V nibble; s=1 low, s=0 high.
  - `0110_xxxx`: JMP, PC←V.
  - `0111_xxxx`: JN, PC←V if N.
  - `0000_00rr`: LD r←mem[V]; rr 00=A, 01=B, 10=V, 11=X.
  - `0001_xxxx`: ST, mem[V]←A.
  - `0010_xxxx`: GET, A←IN.
  - `0011_xxxx`: PUT, OUT←A.
  - `0000_1111`: HALT.
  - All other `0000_xxxx`: NOP.
- States:
  - FETCH: `mem_addr`=PC, `mem_rd`=1; → IRLD.
  - IRLD: IR←`mem_rdata`, PC←PC+1 (mod 256); → EXEC.
  - EXEC, by opcode:
    - ALU: `i7`=1.
    - NIB: `hi_lo_V`=1.
    - JMP/JN: PC update.
    - ST: `mem_addr`=V, `mem_wr`=1.
    - LD: `mem_addr`=V, `mem_rd`=1; → LDWB.
    - GET: `iget`=`in_valid`; stay in EXEC until `in_valid`.
    - PUT: `out_valid`=1; stay until `out_ready`.
    - HALT: → HLT.
    - Otherwise: → FETCH.
  - LDWB: assert the one `set_r` selected by rr; → FETCH.
  - HLT: all strobes 0, `halted`=1; leave only via `rst`.
- `les_leq` = IR[7] & (IR[6:5]==2'b11), i.e. compare ops write {8{N}} into X.
- All control outputs are combinational from state+IR. Every enable is 0 outside the state that owns it; at most one register enable is active per cycle.
- JN with N=0: PC unchanged (already points to next instruction).

## Timing
- Reset: state FETCH, PC=0x00, IR=0x00.
  - Cycle after `rst` deasserts: `mem_rd`=1, `mem_addr`=0x00.
  - All other outputs 0, except `i4`/`i7`/`V_nibble`/`alu_op`, which reflect IR=0.
- `rst` mid-instruction overrides any state, including wait states and HLT. A pending `mem_wr`/`iget`/`out_valid` is dropped that cycle.
- CPI:
  - 3 for ALU/NIB/JMP/JN/ST/NOP.
  - 4 for LD.
  - 3 + wait cycles for GET/PUT.
- GET: `iget`=`in_ack`=1 exactly in the cycle `in_valid`=1; A loads on that edge.
- PUT: `out_valid` held until a cycle with `out_ready`=1; that cycle is the transfer.
- `in_valid`/`out_ready` already high on entry to EXEC: completes in 1 EXEC cycle.
- PC 0xFF fetch → PC wraps to 0x00.

## Structure
- `simp_pkg`: state enum (FETCH, IRLD, EXEC, LDWB, HLT), opcode field constants, rr register-select codes. Shared with the register unit testbench.
- One sub-module `simp_decode`: combinational IR → opcode class, rr, `les_leq`. The sequencer holds PC, IR and the FSM.

## Test plan
- Reset, memory[0]=0x4A, [1]=0x53 → cycle 3 `hi_lo_V`=1, `i4`=0, `V_nibble`=0xA; cycle 6 `hi_lo_V`=1, `i4`=1, `V_nibble`=0x3.
- LD B with V=0x20: IR=0x01 → EXEC `mem_rd`=1, `mem_addr`=0x20; LDWB `set_B`=1 only; next FETCH `mem_addr`=PC.
- JN at PC=0x10, V=0x80: N=1 → next fetch 0x80; N=0 → next fetch 0x11.
- GET with `in_valid` low 5 cycles then high → `iget`=`in_ack`=1 only in the 6th EXEC cycle; PUT, `out_ready` after 2 cycles → `out_valid` high 3 cycles.
- IR=0xE0 → `i7`=1, `les_leq`=1, `alu_op`=6; IR=0x90 → `les_leq`=0.
- Program at 0xFF=NOP → next fetch 0x00; HALT then `rst` pulse mid-HLT → FETCH at 0x00, `halted`=0.
